// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder stage for a streaming radix-2 FFT.
// A ping-pong pair of N-entry complex banks lets one frame be written in
// bit-reversed arrival order while the previous frame is read out in natural
// order. The result is one sample per clock with no gap between frames. The
// per-frame inverse flag is carried across to the output side.
module fft_bitrev_reorder #(
  parameter int N    = 256,
  parameter int LOGN = 8,
  parameter int DW   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic                 sop_in,
  input  logic                 inv_in,
  input  logic signed [DW-1:0] d_re,
  input  logic signed [DW-1:0] d_im,
  output logic                 valid_out,
  output logic                 sop_out,
  output logic                 eop_out,
  output logic                 inv_out,
  output logic signed [DW-1:0] y_re,
  output logic signed [DW-1:0] y_im,
  output logic                 frame_err
);

  typedef enum logic { W_IDLE, W_FILL   } wstate_t;
  typedef enum logic { R_IDLE, R_STREAM } rstate_t;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = a[LOGN-1-i];
    return r;
  endfunction

  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  // Storage: bank select is the MSB of the address.
  logic signed [DW-1:0] mem_re_q [0:2*N-1];
  logic signed [DW-1:0] mem_im_q [0:2*N-1];

  wstate_t         w_state_q, w_state_d;
  logic [LOGN-1:0] wr_cnt_q, wr_cnt_d;
  logic            wb_q, wb_d;
  logic [1:0]      full_q, full_d;
  logic [1:0]      inv_bank_q, inv_bank_d;
  logic            err_q, err_d;

  rstate_t         r_state_q, r_state_d;
  logic [LOGN-1:0] rd_cnt_q, rd_cnt_d;
  logic            rb_q, rb_d;

  logic            we;
  logic [LOGN-1:0] wr_k;
  logic            set_full, clr_full, rd_en, rb_other;

  logic                 valid_q, sop_q, eop_q, inv_q;
  logic signed [DW-1:0] y_re_q, y_im_q;

  assign rb_other = ~rb_q;

  // Write side: track arrival index, handle restarts and frame completion.
  always_comb begin
    w_state_d  = w_state_q;
    wr_cnt_d   = wr_cnt_q;
    wb_d       = wb_q;
    inv_bank_d = inv_bank_q;
    err_d      = 1'b0;
    we         = 1'b0;
    wr_k       = wr_cnt_q;
    set_full   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (valid_in && sop_in) begin
          we             = 1'b1;
          wr_k           = '0;
          wr_cnt_d       = LOGN'(1);
          inv_bank_d[wb_q] = inv_in;
          w_state_d      = W_FILL;
        end
      end
      W_FILL: begin
        if (valid_in && sop_in) begin
          // A new frame start abandons the partial frame in the same bank.
          err_d          = 1'b1;
          we             = 1'b1;
          wr_k           = '0;
          wr_cnt_d       = LOGN'(1);
          inv_bank_d[wb_q] = inv_in;
        end else if (valid_in) begin
          we = 1'b1;
          if (wr_cnt_q == LAST) begin
            set_full  = 1'b1;
            wb_d      = ~wb_q;
            wr_cnt_d  = '0;
            w_state_d = W_IDLE;
          end else begin
            wr_cnt_d = wr_cnt_q + LOGN'(1);
          end
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read side: stream a full bank in natural order, chaining banks without a bubble.
  always_comb begin
    r_state_d = r_state_q;
    rd_cnt_d  = rd_cnt_q;
    rb_d      = rb_q;
    rd_en     = 1'b0;
    clr_full  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (full_q[rb_q]) begin
          r_state_d = R_STREAM;
          rd_cnt_d  = '0;
        end
      end
      R_STREAM: begin
        rd_en = 1'b1;
        if (rd_cnt_q == LAST) begin
          clr_full = 1'b1;
          rb_d     = rb_other;
          rd_cnt_d = '0;
          if (!full_q[rb_other]) r_state_d = R_IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q + LOGN'(1);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Bank full flags: a read completion clears, a write completion sets.
  always_comb begin
    full_d = full_q;
    if (clr_full) full_d[rb_q] = 1'b0;
    if (set_full) full_d[wb_q] = 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q  <= W_IDLE;
      wr_cnt_q   <= '0;
      wb_q       <= 1'b0;
      full_q     <= '0;
      inv_bank_q <= '0;
      err_q      <= 1'b0;
      r_state_q  <= R_IDLE;
      rd_cnt_q   <= '0;
      rb_q       <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      wr_cnt_q   <= wr_cnt_d;
      wb_q       <= wb_d;
      full_q     <= full_d;
      inv_bank_q <= inv_bank_d;
      err_q      <= err_d;
      r_state_q  <= r_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rb_q       <= rb_d;
    end
  end

  // Sample storage, written at the bit-reversed arrival index.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_re_q[{wb_q, bitrev(wr_k)}] <= d_re;
      mem_im_q[{wb_q, bitrev(wr_k)}] <= d_im;
    end
  end

  // Registered read port plus frame markers aligned with the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      inv_q   <= 1'b0;
      y_re_q  <= '0;
      y_im_q  <= '0;
    end else begin
      valid_q <= rd_en;
      sop_q   <= rd_en && (rd_cnt_q == '0);
      eop_q   <= rd_en && (rd_cnt_q == LAST);
      if (rd_en) begin
        y_re_q <= mem_re_q[{rb_q, rd_cnt_q}];
        y_im_q <= mem_im_q[{rb_q, rd_cnt_q}];
        if (rd_cnt_q == '0) inv_q <= inv_bank_q[rb_q];
      end
    end
  end

  assign valid_out = valid_q;
  assign sop_out   = sop_q;
  assign eop_out   = eop_q;
  assign inv_out   = inv_q;
  assign y_re      = y_re_q;
  assign y_im      = y_im_q;
  assign frame_err = err_q;

endmodule
